// File: rtl/fwd_source.sv
// Execute-to-writeback forwarding tracker: X and M slots feed decode operand select,
// M runs the data-memory handshake, W retires into the register file.
package fwd_pkg;
    localparam int XLEN = 64;
    localparam int REGW = 5;

    typedef logic [XLEN-1:0] word_t;
    typedef logic [REGW-1:0] creg_addr_t;

    typedef struct packed {
        creg_addr_t dst;
        word_t      data;
        logic       ismem;
    } tran_t;
endpackage

module fwd_source
    import fwd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       ex_valid,
    input  creg_addr_t ex_dst,
    input  word_t      ex_result,
    input  logic       ex_isload,
    input  logic       ex_isstore,
    input  word_t      ex_wdata,
    input  logic       flush,
    output tran_t      trane,
    output tran_t      tranm,
    output logic       stall,
    output logic       dreq_valid,
    output logic       dreq_write,
    output word_t      dreq_addr,
    output word_t      dreq_wdata,
    input  logic       dresp_valid,
    input  word_t      dresp_rdata,
    output logic       wb_en,
    output creg_addr_t wb_dst,
    output word_t      wb_data
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state;

    logic       x_valid, x_isload, x_isstore;
    creg_addr_t x_dst;
    word_t      x_data, x_wdata;

    logic       m_valid, m_isload, m_isstore;
    creg_addr_t m_dst;
    word_t      m_data, m_wdata;

    logic       w_valid;
    creg_addr_t w_dst;
    word_t      w_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            x_valid <= 1'b0;
            m_valid <= 1'b0;
            w_valid <= 1'b0;
        end else if (state == IDLE) begin
            // Stores retire with dst cleared so W never writes the register file.
            w_valid   <= m_valid;
            w_dst     <= m_isstore ? '0 : m_dst;
            w_data    <= m_data;

            m_valid   <= x_valid;
            m_dst     <= x_dst;
            m_data    <= x_data;
            m_isload  <= x_isload;
            m_isstore <= x_isstore;
            m_wdata   <= x_wdata;
            if (x_valid && (x_isload || x_isstore))
                state <= BUSY;

            x_valid   <= ex_valid && !flush;
            x_dst     <= ex_dst;
            x_data    <= ex_result;
            x_isload  <= ex_isload;
            x_isstore <= ex_isstore;
            x_wdata   <= ex_wdata;
        end else begin
            w_valid <= 1'b0;
            if (flush)
                x_valid <= 1'b0;
            if (dresp_valid) begin
                if (m_isload)
                    m_data <= dresp_rdata;
                state <= IDLE;
            end
        end
    end

    always_comb begin
        trane = '0;
        if (x_valid) begin
            trane.dst   = x_isstore ? '0 : x_dst;
            trane.data  = x_data;
            trane.ismem = x_isload;
        end

        tranm = '0;
        if (m_valid) begin
            tranm.dst  = (m_isstore || state == BUSY) ? '0 : m_dst;
            tranm.data = m_data;
        end
    end

    assign stall      = (state == BUSY);
    assign dreq_valid = stall;
    assign dreq_write = stall && m_isstore;
    assign dreq_addr  = stall ? m_data  : '0;
    assign dreq_wdata = stall ? m_wdata : '0;

    assign wb_en   = w_valid && (w_dst != '0);
    assign wb_dst  = wb_en ? w_dst  : '0;
    assign wb_data = wb_en ? w_data : '0;

endmodule

// File: tb/tb_fwd_source.sv
// Directed, table-driven bench for fwd_source: pipeline forwarding, memory stalls,
// flush, and reset abandoning an outstanding request.
module tb_fwd_source;
    import fwd_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       ex_valid, ex_isload, ex_isstore, flush, dresp_valid;
    creg_addr_t ex_dst;
    word_t      ex_result, ex_wdata, dresp_rdata;
    tran_t      trane, tranm;
    logic       stall, dreq_valid, dreq_write, wb_en;
    word_t      dreq_addr, dreq_wdata, wb_data;
    creg_addr_t wb_dst;

    int total = 0;
    int bad   = 0;

    fwd_source dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_dst(ex_dst), .ex_result(ex_result),
        .ex_isload(ex_isload), .ex_isstore(ex_isstore), .ex_wdata(ex_wdata),
        .flush(flush), .trane(trane), .tranm(tranm), .stall(stall),
        .dreq_valid(dreq_valid), .dreq_write(dreq_write), .dreq_addr(dreq_addr),
        .dreq_wdata(dreq_wdata), .dresp_valid(dresp_valid), .dresp_rdata(dresp_rdata),
        .wb_en(wb_en), .wb_dst(wb_dst), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ev;
        creg_addr_t dst;
        word_t      res;
        logic       ld, st;
        word_t      wd;
        logic       fl, rv;
        word_t      rd;
        tran_t      e_trane, e_tranm;
        logic       e_stall, e_dv, e_dw;
        word_t      e_da, e_dd;
        logic       e_we;
        creg_addr_t e_wdst;
        word_t      e_wdata;
    } vec_t;

    vec_t vecs[$];

    function automatic tran_t tr(input logic [4:0] d, input logic [63:0] v, input logic m);
        tran_t t;
        t.dst = d; t.data = v; t.ismem = m;
        return t;
    endfunction

    task automatic add(input logic ev, input logic [4:0] dst, input logic [63:0] res,
                       input logic ld, input logic st, input logic [63:0] wd,
                       input logic fl, input logic rv, input logic [63:0] rd,
                       input tran_t et, input tran_t em, input logic es,
                       input logic edv, input logic edw, input logic [63:0] eda,
                       input logic [63:0] edd, input logic ewe, input logic [4:0] ewdst,
                       input logic [63:0] ewdata);
        vec_t v;
        v.ev = ev; v.dst = dst; v.res = res; v.ld = ld; v.st = st; v.wd = wd;
        v.fl = fl; v.rv = rv; v.rd = rd;
        v.e_trane = et; v.e_tranm = em; v.e_stall = es;
        v.e_dv = edv; v.e_dw = edw; v.e_da = eda; v.e_dd = edd;
        v.e_we = ewe; v.e_wdst = ewdst; v.e_wdata = ewdata;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic ev, input logic [4:0] dst, input logic [63:0] res,
                         input logic ld, input logic st, input logic [63:0] wd,
                         input logic fl, input logic rv, input logic [63:0] rd);
        ex_valid = ev; ex_dst = dst; ex_result = res; ex_isload = ld;
        ex_isstore = st; ex_wdata = wd; flush = fl; dresp_valid = rv; dresp_rdata = rd;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tran_t z;
        z = tr(0, 0, 0);

        //  ev dst res     ld st wd     fl rv rd         trane                tranm               st dv dw addr    wdata   we wdst wdata
        add(1, 5, 'h10,  0, 0, 0,    0, 0, 0,       tr(5, 'h10, 0),  z,                  0, 0, 0, 0,      0,      0, 0, 0);
        add(1, 6, 'h20,  0, 0, 0,    0, 0, 0,       tr(6, 'h20, 0),  tr(5, 'h10, 0),     0, 0, 0, 0,      0,      0, 0, 0);
        add(1, 7, 'h80,  1, 0, 0,    0, 0, 0,       tr(7, 'h80, 1),  tr(6, 'h20, 0),     0, 0, 0, 0,      0,      1, 5, 'h10);
        add(1, 3, 'h33,  0, 0, 0,    0, 0, 0,       tr(3, 'h33, 0),  tr(0, 'h80, 0),     1, 1, 0, 'h80,   0,      1, 6, 'h20);
        add(1, 9, 'h99,  0, 0, 0,    0, 0, 0,       tr(3, 'h33, 0),  tr(0, 'h80, 0),     1, 1, 0, 'h80,   0,      0, 0, 0);
        add(0, 0, 0,     0, 0, 0,    0, 0, 0,       tr(3, 'h33, 0),  tr(0, 'h80, 0),     1, 1, 0, 'h80,   0,      0, 0, 0);
        add(0, 0, 0,     0, 0, 0,    0, 1, 'hDEAD,  tr(3, 'h33, 0),  tr(7, 'hDEAD, 0),   0, 0, 0, 0,      0,      0, 0, 0);
        add(1, 4, 'h40,  0, 1, 'h55, 0, 0, 0,       tr(0, 'h40, 0),  tr(3, 'h33, 0),     0, 0, 0, 0,      0,      1, 7, 'hDEAD);
        add(0, 0, 0,     0, 0, 0,    0, 0, 0,       z,               tr(0, 'h40, 0),     1, 1, 1, 'h40,   'h55,   1, 3, 'h33);
        add(0, 0, 0,     0, 0, 0,    0, 1, 'hBEEF,  z,               tr(0, 'h40, 0),     0, 0, 0, 0,      0,      0, 0, 0);
        add(0, 0, 0,     0, 0, 0,    0, 0, 0,       z,               z,                  0, 0, 0, 0,      0,      0, 0, 0);
        add(1, 1, 'h11,  0, 0, 0,    1, 1, 'h77,    z,               z,                  0, 0, 0, 0,      0,      0, 0, 0);
        add(1, 8, 'h100, 1, 0, 0,    0, 0, 0,       tr(8, 'h100, 1), z,                  0, 0, 0, 0,      0,      0, 0, 0);
        add(1, 3, 'h44,  0, 0, 0,    0, 0, 0,       tr(3, 'h44, 0),  tr(0, 'h100, 0),    1, 1, 0, 'h100,  0,      0, 0, 0);
        add(0, 0, 0,     0, 0, 0,    1, 1, 'h1234,  z,               tr(8, 'h1234, 0),   0, 0, 0, 0,      0,      0, 0, 0);
        add(0, 0, 0,     0, 0, 0,    0, 0, 0,       z,               z,                  0, 0, 0, 0,      0,      1, 8, 'h1234);

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("reset trane", trane, z);
        chk("reset tranm", tranm, z);
        chk("reset stall", stall, 0);
        chk("reset dreq_valid", dreq_valid, 0);
        chk("reset wb_en", wb_en, 0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].ev, vecs[i].dst, vecs[i].res, vecs[i].ld, vecs[i].st,
                  vecs[i].wd, vecs[i].fl, vecs[i].rv, vecs[i].rd);
            tick();
            chk($sformatf("r%0d trane", i), trane, vecs[i].e_trane);
            chk($sformatf("r%0d tranm", i), tranm, vecs[i].e_tranm);
            chk($sformatf("r%0d stall", i), stall, vecs[i].e_stall);
            chk($sformatf("r%0d dreq_valid", i), dreq_valid, vecs[i].e_dv);
            if (vecs[i].e_dv) begin
                chk($sformatf("r%0d dreq_write", i), dreq_write, vecs[i].e_dw);
                chk($sformatf("r%0d dreq_addr", i), dreq_addr, vecs[i].e_da);
                if (vecs[i].e_dw)
                    chk($sformatf("r%0d dreq_wdata", i), dreq_wdata, vecs[i].e_dd);
            end
            chk($sformatf("r%0d wb_en", i), wb_en, vecs[i].e_we);
            if (vecs[i].e_we) begin
                chk($sformatf("r%0d wb_dst", i), wb_dst, vecs[i].e_wdst);
                chk($sformatf("r%0d wb_data", i), wb_data, vecs[i].e_wdata);
            end
        end

        // Reset while a load is outstanding, then a late response.
        drive(1, 2, 'h200, 1, 0, 0, 0, 0, 0);
        tick();
        drive(1, 4, 'h44, 0, 0, 0, 0, 0, 0);
        tick();
        chk("rb stall", stall, 1);
        chk("rb dreq_addr", dreq_addr, 64'h200);
        chk("rb trane", trane, tr(4, 'h44, 0));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_busy stall", stall, 0);
        chk("rst_busy dreq_valid", dreq_valid, 0);
        chk("rst_busy trane", trane, z);
        chk("rst_busy tranm", tranm, z);
        chk("rst_busy wb_en", wb_en, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 'hAA);
        tick();
        chk("late_resp stall", stall, 0);
        chk("late_resp tranm", tranm, z);
        chk("late_resp dreq_valid", dreq_valid, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("late_resp wb_en", wb_en, 0);
        chk("late_resp stall2", stall, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
